// File: rtl/punch_anim_ctrl.sv
// Punch animation sequencer and sprite-ROM address generator.
// The FSM walks IDLE -> WINDUP -> STRIKE -> RECOVER on vsync ticks, with a
// one-deep combo buffer. The pixel path maps the VGA position into the sprite
// box and then qualifies the returned palette index.
module punch_anim_ctrl #(
    parameter int FRAME_W    = 64,
    parameter int FRAME_H    = 96,
    parameter int HOLD_TICKS = 6,
    parameter int ADDR_W     = 15
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync_tick,
    input  logic              punch_req,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              facing_left,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [3:0]        rom_index,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        pix_index,
    output logic              sprite_on,
    output logic              busy,
    output logic [1:0]        frame_sel,
    output logic              anim_done
);

    // The state encoding doubles as the animation frame number.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDUP  = 2'd1,
        STRIKE  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(FRAME_W * FRAME_H);
    localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(FRAME_W);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               busy_q, busy_d;
    logic [1:0]         frame_sel_q, frame_sel_d;
    logic               anim_done_q, anim_done_d;

    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               hit_d1_q, hit_d2_q;
    logic [3:0]         pix_index_q, pix_index_d;
    logic               sprite_on_q, sprite_on_d;

    logic               hit;
    logic               last_tick;
    logic               combo;

    // Next-state logic: hold counter, combo buffer, tear-free frame select.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        anim_done_d = 1'b0;
        frame_sel_d = frame_sel_q;
        last_tick   = vsync_tick && (cnt_q == HOLD_LAST);
        combo       = pending_q || punch_req;

        if (vsync_tick) begin
            frame_sel_d = 2'(state_q);
        end

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                pending_d = 1'b0;
                if (punch_req) begin
                    state_d = WINDUP;
                end
            end
            WINDUP: begin
                if (last_tick) begin
                    state_d = STRIKE;
                    cnt_d   = '0;
                end else if (vsync_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STRIKE: begin
                if (punch_req) begin
                    pending_d = 1'b1;
                end
                if (last_tick) begin
                    state_d = RECOVER;
                    cnt_d   = '0;
                end else if (vsync_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RECOVER: begin
                pending_d = combo;
                if (last_tick) begin
                    state_d     = combo ? WINDUP : IDLE;
                    pending_d   = 1'b0;
                    anim_done_d = 1'b1;
                    cnt_d       = '0;
                end else if (vsync_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FSM and its registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_sel_q <= 2'd0;
            anim_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            frame_sel_q <= frame_sel_d;
            anim_done_q <= anim_done_d;
        end
    end

    // Box test and ROM address; 11-bit math keeps pos+size from wrapping.
    always_comb begin
        logic [10:0] x_lo;
        logic [10:0] x_hi;
        logic [10:0] y_lo;
        logic [10:0] y_hi;
        logic [10:0] px;
        logic [10:0] py;
        logic [10:0] dx;
        logic [10:0] dy;
        logic [10:0] lx;

        x_lo = {1'b0, pos_x};
        y_lo = {1'b0, pos_y};
        x_hi = x_lo + 11'(FRAME_W);
        y_hi = y_lo + 11'(FRAME_H);
        px   = {1'b0, draw_x};
        py   = {1'b0, draw_y};
        dx   = px - x_lo;
        dy   = py - y_lo;
        lx   = facing_left ? (11'(FRAME_W - 1) - dx) : dx;

        hit = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);

        rom_addr_d = '0;
        if (hit) begin
            rom_addr_d = ADDR_W'(frame_sel_q) * FRAME_SIZE
                       + ADDR_W'(dy) * ROW_SIZE
                       + ADDR_W'(lx);
        end
    end

    // Transparency qualification of the palette index returned by the ROM.
    always_comb begin
        sprite_on_d = hit_d2_q && (rom_index != 4'd0);
        pix_index_d = hit_d2_q ? rom_index : 4'd0;
    end

    // Pixel pipeline: address at N+1, hit aligned to ROM data at N+2, result at N+3.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            hit_d1_q    <= 1'b0;
            hit_d2_q    <= 1'b0;
            pix_index_q <= 4'd0;
            sprite_on_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            hit_d1_q    <= hit;
            hit_d2_q    <= hit_d1_q;
            pix_index_q <= pix_index_d;
            sprite_on_q <= sprite_on_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_index = pix_index_q;
    assign sprite_on = sprite_on_q;
    assign busy      = busy_q;
    assign frame_sel = frame_sel_q;
    assign anim_done = anim_done_q;

endmodule

// File: tb/tb_punch_anim_ctrl.sv
// Self-checking bench for punch_anim_ctrl: directed scenarios plus random
// traffic, compared every cycle against a punch-timeline reference model.
module tb_punch_anim_ctrl;

    localparam int FRAME_W = 64;
    localparam int FRAME_H = 96;
    localparam int HOLD    = 2;
    localparam int ADDR_W  = 15;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              vsync_tick = 1'b0;
    logic              punch_req = 1'b0;
    logic [9:0]        pos_x = 10'd0;
    logic [9:0]        pos_y = 10'd0;
    logic              facing_left = 1'b0;
    logic [9:0]        draw_x = 10'd0;
    logic [9:0]        draw_y = 10'd0;
    logic [3:0]        rom_index = 4'd0;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        pix_index;
    logic              sprite_on;
    logic              busy;
    logic [1:0]        frame_sel;
    logic              anim_done;

    punch_anim_ctrl #(
        .FRAME_W   (FRAME_W),
        .FRAME_H   (FRAME_H),
        .HOLD_TICKS(HOLD),
        .ADDR_W    (ADDR_W)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .vsync_tick (vsync_tick),
        .punch_req  (punch_req),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .facing_left(facing_left),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .rom_index  (rom_index),
        .rom_addr   (rom_addr),
        .pix_index  (pix_index),
        .sprite_on  (sprite_on),
        .busy       (busy),
        .frame_sel  (frame_sel),
        .anim_done  (anim_done)
    );

    // 100 MHz system clock.
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a punch is a timeline of 3*HOLD counted ticks.
    bit m_active;
    bit m_combo;
    bit m_done;
    int m_ticks;
    int m_frame;
    bit hit_q[$];
    int exp_addr;
    int exp_pix;
    bit exp_son;

    // Observations gathered while running tick sequences.
    int done_seen;
    int fs_changes[$];
    logic [1:0] last_fs;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input bit req, input bit tick, input int x, input int y, input int rom);
        punch_req  = req;
        vsync_tick = tick;
        draw_x     = 10'(x);
        draw_y     = 10'(y);
        rom_index  = 4'(rom);
    endtask

    function automatic int near(input logic [9:0] base);
        int v;
        v = int'(base) + int'($urandom_range(0, 120)) - 20;
        return v & 1023;
    endfunction

    task automatic resetModel();
        m_active = 1'b0;
        m_combo  = 1'b0;
        m_done   = 1'b0;
        m_ticks  = 0;
        m_frame  = 0;
        hit_q    = '{1'b0, 1'b0};
    endtask

    // Predict the outputs seen after the coming clock edge from the present inputs.
    task automatic predictEdge();
        int px, py, dx, dy, lx, phase;
        bit hit_now, hit_old;
        px = int'(pos_x);
        py = int'(pos_y);
        dx = int'(draw_x);
        dy = int'(draw_y);
        hit_now = (dx >= px) && (dx < px + FRAME_W) && (dy >= py) && (dy < py + FRAME_H);
        lx = dx - px;
        if (facing_left) lx = FRAME_W - 1 - lx;
        exp_addr = hit_now ? (m_frame * FRAME_W * FRAME_H + (dy - py) * FRAME_W + lx) : 0;

        hit_old = hit_q.pop_front();
        hit_q.push_back(hit_now);
        exp_son = hit_old && (rom_index != 4'd0);
        exp_pix = hit_old ? int'(rom_index) : 0;

        phase = m_active ? 1 + m_ticks / HOLD : 0;
        if (vsync_tick) m_frame = phase;
        m_done = 1'b0;
        if (!m_active) begin
            if (punch_req) begin
                m_active = 1'b1;
                m_ticks  = 0;
                m_combo  = 1'b0;
            end
        end else begin
            if (phase >= 2 && punch_req) m_combo = 1'b1;
            if (vsync_tick) begin
                m_ticks++;
                if (m_ticks == 3 * HOLD) begin
                    m_done  = 1'b1;
                    m_ticks = 0;
                    if (m_combo) m_combo = 1'b0;
                    else m_active = 1'b0;
                end
            end
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic stepCycle();
        predictEdge();
        @(posedge Clk);
        #1;
        checkOutput("rom_addr", 32'(rom_addr), exp_addr);
        checkOutput("pix_index", 32'(pix_index), exp_pix);
        checkOutput("sprite_on", 32'(sprite_on), 32'(exp_son));
        checkOutput("busy", 32'(busy), 32'(m_active));
        checkOutput("frame_sel", 32'(frame_sel), m_frame);
        checkOutput("anim_done", 32'(anim_done), 32'(m_done));
        if (anim_done) done_seen++;
        if (frame_sel != last_fs) fs_changes.push_back(int'(frame_sel));
        last_fs = frame_sel;
    endtask

    // Run nticks ticks spaced gap cycles apart; optional request after tick req_tick.
    task automatic runTicks(input int nticks, input int gap, input int req_tick);
        for (int t = 1; t <= nticks; t++) begin
            for (int c = 0; c < gap; c++) begin
                applyStimulus((req_tick > 0) && (t == req_tick + 1) && (c == 0), c == gap - 1,
                              near(pos_x), near(pos_y), int'($urandom_range(0, 15)));
                stepCycle();
            end
        end
    endtask

    task automatic startPunch();
        applyStimulus(1'b1, 1'b0, 0, 0, 0);
        stepCycle();
    endtask

    int tbl_x[6]   = '{100, 163, 164, 99, 0, 0};
    int tbl_y[6]   = '{50, 145, 50, 50, 0, 0};
    int tbl_rom[6] = '{0, 0, 5, 7, 9, 9};
    int tbl_adr[6] = '{0, 6143, 0, 0, 0, 0};
    int tbl_son[6] = '{0, 0, 1, 1, 0, 0};
    int tbl_pix[6] = '{0, 0, 5, 7, 0, 0};

    initial begin
        resetModel();
        last_fs   = 2'd0;
        done_seen = 0;

        // Reset values.
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset_rom_addr", 32'(rom_addr), 0);
        checkOutput("reset_pix_index", 32'(pix_index), 0);
        checkOutput("reset_sprite_on", 32'(sprite_on), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_frame_sel", 32'(frame_sel), 0);
        checkOutput("reset_anim_done", 32'(anim_done), 0);
        Reset_n = 1'b1;
        pos_x   = 10'd100;
        pos_y   = 10'd50;

        // Single punch with widely spaced ticks.
        $display("[TB] single punch");
        fs_changes.delete();
        done_seen = 0;
        startPunch();
        checkOutput("busy_after_accept", 32'(busy), 1);
        runTicks(7, 100, 0);
        checkOutput("single_fs_count", 32'(fs_changes.size()), 4);
        if (fs_changes.size() == 4) begin
            checkOutput("single_fs0", 32'(fs_changes[0]), 1);
            checkOutput("single_fs1", 32'(fs_changes[1]), 2);
            checkOutput("single_fs2", 32'(fs_changes[2]), 3);
            checkOutput("single_fs3", 32'(fs_changes[3]), 0);
        end
        checkOutput("single_done_count", 32'(done_seen), 1);
        checkOutput("single_busy_end", 32'(busy), 0);

        // Combo: request during STRIKE chains a second punch.
        $display("[TB] combo from strike");
        done_seen = 0;
        startPunch();
        runTicks(6, 10, 3);
        checkOutput("combo_busy_held", 32'(busy), 1);
        checkOutput("combo_done_first", 32'(done_seen), 1);
        runTicks(8, 10, 0);
        checkOutput("combo_done_count", 32'(done_seen), 2);
        checkOutput("combo_busy_end", 32'(busy), 0);

        // Request during WINDUP is dropped.
        $display("[TB] request during windup");
        done_seen = 0;
        startPunch();
        runTicks(8, 10, 1);
        checkOutput("windup_done_count", 32'(done_seen), 1);
        checkOutput("windup_busy_end", 32'(busy), 0);
        checkOutput("windup_frame_idle", 32'(frame_sel), 0);

        // Box edges, then transparency, with frame 0 displayed.
        $display("[TB] box edges and transparency");
        facing_left = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 0);
            stepCycle();
            stepCycle();
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1'b0, 1'b0, tbl_x[i], tbl_y[i],
                              (pass == 1 && i == 2) ? 0 : tbl_rom[i]);
                stepCycle();
                checkOutput("box_addr", 32'(rom_addr), tbl_adr[i]);
                checkOutput("box_sprite_on", 32'(sprite_on),
                            (pass == 1 && i == 2) ? 0 : tbl_son[i]);
                checkOutput("box_pix_index", 32'(pix_index),
                            (pass == 1 && i == 2) ? 0 : tbl_pix[i]);
            end
        end

        // Mirroring at frame 0 and frame 2, then reset in the middle of STRIKE.
        $display("[TB] mirroring and reset mid-strike");
        facing_left = 1'b1;
        applyStimulus(1'b0, 1'b0, 100, 50, 0);
        stepCycle();
        checkOutput("mirror_f0", 32'(rom_addr), 63);
        startPunch();
        runTicks(3, 5, 0);
        checkOutput("frame_sel_strike", 32'(frame_sel), 2);
        facing_left = 1'b1;
        applyStimulus(1'b0, 1'b0, 100, 50, 0);
        stepCycle();
        checkOutput("mirror_f2", 32'(rom_addr), 12351);
        applyStimulus(1'b0, 1'b0, 100, 50, 6);
        stepCycle();
        stepCycle();
        checkOutput("pre_reset_busy", 32'(busy), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("midreset_rom_addr", 32'(rom_addr), 0);
        checkOutput("midreset_pix_index", 32'(pix_index), 0);
        checkOutput("midreset_sprite_on", 32'(sprite_on), 0);
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_frame_sel", 32'(frame_sel), 0);
        checkOutput("midreset_anim_done", 32'(anim_done), 0);
        repeat (2) @(posedge Clk);
        #1;
        resetModel();
        Reset_n = 1'b1;
        runTicks(4, 5, 0);
        checkOutput("idle_after_reset", 32'(busy), 0);

        // Random traffic against the model.
        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                pos_x = 10'($urandom_range(0, 1023));
                pos_y = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 15) == 0) facing_left = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                          near(pos_x), near(pos_y),
                          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)));
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
